debug_settings_ctl: RTL and testbench
=====================================

Name: debug_settings_ctl

Overview:
- Sequences loading of the four GPIO debug-channel settings (type and value per channel) from the controller BRAM into the debug mux settings struct.
- Sanitises each entry and commits all four channels atomically on a carrier-period boundary (TIME_CNT wrap), so GPIO outputs never glitch mid-period.
- Sits between the controller memory bus and the debug output mux.

Parameters:
- DEPTH, 249: number of transducer PWM outputs; PWM_OUT entries with value >= DEPTH are invalid.
- RD_LATENCY, 2: BRAM read latency in cycles, address to data valid; legal range 1..4.
- BASE_ADDR, 8'h00: BRAM word address of TYPE0.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- UPDATE  in  1  load request; level signal from the controller flag register, rising edge triggers a load.
- TIME_CNT  in  8  carrier period counter; wraps 255 -> 0.
- BRAM_ADDR  out  8  read address to controller BRAM.
- BRAM_EN  out  1  read enable.
- BRAM_DOUT  in  16  read data, valid RD_LATENCY cycles after address/EN.
- DEBUG_SETTINGS  out  settings::debug_settings_t  committed TYPE[4] (8b) and VALUE[4] (16b).
- BUSY  out  1  high from accepted request until commit.
- DONE  out  1  one-cycle pulse on the commit cycle.

Behaviour:
- Reset values: DEBUG_SETTINGS all TYPE = DBG_NONE (0), all VALUE = 0; BRAM_ADDR = 0; BRAM_EN = 0; BUSY = 0; DONE = 0; all state, shadow registers and pending flag cleared.
- Reset mid-operation aborts the load; committed settings return to the reset values.
- BRAM memory map, word offsets from BASE_ADDR:
  - +0..+3: TYPE0..TYPE3 (bits [7:0]; [15:8] ignored).
  - +4..+7: VALUE0..VALUE3 (full 16 bits).
- Edge detect: UPDATE is registered once; req = UPDATE & ~UPDATE_q.
- FSM states: IDLE, READ, DRAIN, CHECK, ARM.
- IDLE: on req, go to READ, set BUSY and clear the read index.
- READ: 8 consecutive cycles with BRAM_EN = 1 and BRAM_ADDR = BASE_ADDR + idx, idx 0..7. After idx 7, go to DRAIN; BRAM_EN deasserts.
- Capture pipeline: a RD_LATENCY-deep shift register of (valid, idx) tags. When the tag emerges, BRAM_DOUT is written into shadow slot idx. No stall; BRAM is assumed always ready.
- DRAIN: wait until the last tag (idx 7) has been captured, then go to CHECK.
- CHECK (1 cycle), per channel, in parallel:
  - TYPE > DBG_DIRECT (unknown) -> TYPE forced to DBG_NONE, VALUE forced to 0.
  - TYPE == DBG_PWM_OUT and VALUE >= DEPTH -> forced to DBG_NONE, VALUE 0.
  - DBG_MOD_IDX: VALUE masked to [14:0]. DBG_STM_IDX: VALUE masked to [12:0]. DBG_DIRECT: VALUE masked to [0].
  - Then go to ARM.
- ARM: wait for TIME_CNT == 8'hFF. In that cycle, copy all four sanitised shadow entries into DEBUG_SETTINGS, pulse DONE, clear BUSY, return to IDLE. New settings therefore take effect from TIME_CNT == 0.
- Entering ARM while TIME_CNT == 8'hFF commits in that same cycle, with no extra period of delay.
- Worst-case request-to-commit latency: 1 + 8 + RD_LATENCY + 1 + 256 cycles.
- Request while BUSY: set a one-deep pending flag; further requests merge into it. After the commit cycle, if pending is set, clear it and start READ in the next cycle without returning through IDLE.
- Request in the same cycle as the commit: treated as pending, so a new load starts.
- DEBUG_SETTINGS changes only on the commit cycle; a partial update is never visible.

Decomposition:
- settings package: debug_settings_t (existing) only.
- params package: DBG_* type codes (existing), plus new constants:
  - DBG_TYPE_MAX = DBG_DIRECT.
  - DBG_SETTINGS_WORDS = 8.
  - DBG_SETTINGS_BASE.
- FSM state enum: local to the module.
- Sub-module: debug_entry_sanitize. Combinational, one instance per channel. Inputs: type, value, DEPTH. Outputs: sanitised type and value.

Test Plan:
- Basic load: BRAM holds TYPE {1,4,10,11}, VALUE {0,0,17,1}. Pulse UPDATE at TIME_CNT=10 -> BRAM_ADDR steps 0..7 over 8 cycles. DEBUG_SETTINGS unchanged until the cycle TIME_CNT=255, then equals the loaded values; DONE pulses once; BUSY falls in the same cycle.
- Sanitise:
  - TYPE0 = 8'h7F -> (DBG_NONE, 0).
  - TYPE1 = DBG_PWM_OUT, VALUE 249 -> (DBG_NONE, 0).
  - TYPE2 = DBG_PWM_OUT, VALUE 248 -> kept.
  - TYPE3 = DBG_MOD_IDX, VALUE 16'hFFFF -> VALUE 16'h7FFF.
- Boundary commit: set RD_LATENCY=2 and time UPDATE so that ARM is entered exactly when TIME_CNT=255 -> commit in that same cycle. Entering ARM at TIME_CNT=0 -> commit 255 cycles later.
- Back-to-back requests: toggle UPDATE three times during READ, changing BRAM contents between loads -> exactly two loads occur (second from pending) and exactly two DONE pulses; final settings equal the BRAM contents at the second load.
- Reset mid-load: assert RST_N=0 during DRAIN -> outputs immediately return to reset values. After release, no commit occurs without a new UPDATE edge, and UPDATE held high across reset causes no load.
- Latency sweep: repeat the basic load with RD_LATENCY 1, 3 and 4 -> identical committed values, with DRAIN length tracking RD_LATENCY.

Source files
------------

// File: rtl/debug_settings_ctl_pkg.sv
// Shared definitions for the debug-channel settings loader: debug type codes,
// settings memory layout constants and the committed settings struct.
package debug_settings_ctl_pkg;

  // Debug channel type codes as stored in the controller BRAM.
  localparam logic [7:0] DBG_NONE        = 8'd0;
  localparam logic [7:0] DBG_BASE_SIG    = 8'd1;
  localparam logic [7:0] DBG_THERMO      = 8'd2;
  localparam logic [7:0] DBG_FORCE_FAN   = 8'd3;
  localparam logic [7:0] DBG_SYNC        = 8'd4;
  localparam logic [7:0] DBG_MOD_SEGMENT = 8'd5;
  localparam logic [7:0] DBG_MOD_IDX     = 8'd6;
  localparam logic [7:0] DBG_STM_SEGMENT = 8'd7;
  localparam logic [7:0] DBG_STM_IDX     = 8'd8;
  localparam logic [7:0] DBG_IS_STM_MODE = 8'd9;
  localparam logic [7:0] DBG_PWM_OUT     = 8'd10;
  localparam logic [7:0] DBG_DIRECT      = 8'd11;

  // Highest type code the debug mux understands; anything above is unknown.
  localparam logic [7:0] DBG_TYPE_MAX = DBG_DIRECT;

  // Settings block layout: four TYPE words followed by four VALUE words.
  localparam int         DBG_SETTINGS_WORDS = 8;
  localparam int         DBG_CHANNELS       = 4;
  localparam logic [7:0] DBG_SETTINGS_BASE  = 8'h00;

  // Committed settings seen by the debug output mux.
  typedef struct packed {
    logic [3:0][7:0]  dbg_type;
    logic [3:0][15:0] dbg_value;
  } debug_settings_t;

endpackage

// File: rtl/debug_settings_ctl_entry_sanitize.sv
// Combinational clean-up of one debug channel entry: unknown types and
// out-of-range PWM indices collapse to DBG_NONE, index values are masked to
// the width the mux actually decodes.
module debug_entry_sanitize
  import debug_settings_ctl_pkg::*;
#(
  parameter int DEPTH = 249
) (
  input  logic [7:0]  type_i,
  input  logic [15:0] value_i,
  output logic [7:0]  type_o,
  output logic [15:0] value_o
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  // Per-type sanitise rules; pass-through is the default.
  always_comb begin
    type_o  = type_i;
    value_o = value_i;
    if (type_i > DBG_TYPE_MAX) begin
      type_o  = DBG_NONE;
      value_o = '0;
    end else if ((type_i == DBG_PWM_OUT) && (value_i >= DEPTH_W)) begin
      type_o  = DBG_NONE;
      value_o = '0;
    end else if (type_i == DBG_MOD_IDX) begin
      value_o = value_i & 16'h7FFF;
    end else if (type_i == DBG_STM_IDX) begin
      value_o = value_i & 16'h1FFF;
    end else if (type_i == DBG_DIRECT) begin
      value_o = value_i & 16'h0001;
    end
  end

endmodule

// File: rtl/debug_settings_ctl.sv
// Loads the four debug channel settings from controller BRAM into shadow
// registers, sanitises them, and commits all channels together on the cycle
// TIME_CNT == 8'hFF so the new settings apply from the start of a carrier
// period.
//
// BRAM interface: an address is issued every cycle BRAM_EN is high; there is
// no back-pressure, and BRAM_DOUT for that address is taken exactly
// RD_LATENCY cycles later, tracked by a tag pipeline rather than a ready.
module debug_settings_ctl
  import debug_settings_ctl_pkg::*;
#(
  parameter int         DEPTH      = 249,
  parameter int         RD_LATENCY = 2,
  parameter logic [7:0] BASE_ADDR  = DBG_SETTINGS_BASE
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            UPDATE,
  input  logic [7:0]      TIME_CNT,
  output logic [7:0]      BRAM_ADDR,
  output logic            BRAM_EN,
  input  logic [15:0]     BRAM_DOUT,
  output debug_settings_t DEBUG_SETTINGS,
  output logic            BUSY,
  output logic            DONE,
  output logic [2:0]      DBG_FSM_STATE
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_ARM   = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       pending_q, pending_d;
  logic       update_q;
  logic       edge_arm_q;
  logic       done_q, done_d;
  logic       req;

  logic [3:0][7:0]  shadow_type_q, shadow_type_d;
  logic [3:0][15:0] shadow_value_q, shadow_value_d;
  debug_settings_t  settings_q, settings_d;

  logic [RD_LATENCY-1:0]      tag_valid_q, tag_valid_d;
  logic [RD_LATENCY-1:0][2:0] tag_idx_q, tag_idx_d;
  logic                       cap_valid;
  logic [2:0]                 cap_idx;

  logic       bram_en;
  logic [7:0] bram_addr;

  logic [7:0]  san_type  [DBG_CHANNELS];
  logic [15:0] san_value [DBG_CHANNELS];

  // edge_arm_q suppresses an edge on the first cycle after reset, so a level
  // already high across reset is not mistaken for a new request.
  assign req = edge_arm_q & UPDATE & ~update_q;

  assign cap_valid = tag_valid_q[RD_LATENCY-1];
  assign cap_idx   = tag_idx_q[RD_LATENCY-1];

  genvar g;
  generate
    for (g = 0; g < DBG_CHANNELS; g++) begin : g_san
      debug_entry_sanitize #(.DEPTH(DEPTH)) u_san (
        .type_i  (shadow_type_q[g]),
        .value_i (shadow_value_q[g]),
        .type_o  (san_type[g]),
        .value_o (san_value[g])
      );
    end
  endgenerate

  // Tag pipeline: follows each issued read until its data is on BRAM_DOUT.
  always_comb begin
    tag_valid_d    = tag_valid_q;
    tag_idx_d      = tag_idx_q;
    tag_valid_d[0] = bram_en;
    tag_idx_d[0]   = idx_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_idx_d[i]   = tag_idx_q[i-1];
    end
  end

  // Next-state, read issue, capture, sanitise and commit.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pending_d      = pending_q;
    done_d         = 1'b0;
    shadow_type_d  = shadow_type_q;
    shadow_value_d = shadow_value_q;
    settings_d     = settings_q;
    bram_en        = 1'b0;
    bram_addr      = '0;

    // Requests arriving while a load is in flight merge into one pending load.
    if (req && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    // Indices 0..3 are TYPE words, 4..7 are VALUE words.
    if (cap_valid) begin
      if (cap_idx[2]) begin
        shadow_value_d[cap_idx[1:0]] = BRAM_DOUT;
      end else begin
        shadow_type_d[cap_idx[1:0]] = BRAM_DOUT[7:0];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
      end
      ST_READ: begin
        bram_en   = 1'b1;
        bram_addr = BASE_ADDR + {5'd0, idx_q};
        if (idx_q == 3'd7) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (cap_valid && (cap_idx == 3'd7)) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        for (int c = 0; c < DBG_CHANNELS; c++) begin
          shadow_type_d[c]  = san_type[c];
          shadow_value_d[c] = san_value[c];
        end
        state_d = ST_ARM;
      end
      ST_ARM: begin
        if (TIME_CNT == 8'hFF) begin
          settings_d.dbg_type  = shadow_type_q;
          settings_d.dbg_value = shadow_value_q;
          done_d               = 1'b1;
          if (pending_q || req) begin
            pending_d = 1'b0;
            state_d   = ST_READ;
            idx_d     = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: edge detect, index, tags, shadow and committed settings.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q          <= '0;
      pending_q      <= 1'b0;
      update_q       <= 1'b0;
      edge_arm_q     <= 1'b0;
      done_q         <= 1'b0;
      tag_valid_q    <= '0;
      tag_idx_q      <= '0;
      shadow_type_q  <= '0;
      shadow_value_q <= '0;
      settings_q     <= '0;
    end else begin
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      update_q       <= UPDATE;
      edge_arm_q     <= 1'b1;
      done_q         <= done_d;
      tag_valid_q    <= tag_valid_d;
      tag_idx_q      <= tag_idx_d;
      shadow_type_q  <= shadow_type_d;
      shadow_value_q <= shadow_value_d;
      settings_q     <= settings_d;
    end
  end

  assign BRAM_EN        = bram_en;
  assign BRAM_ADDR      = bram_addr;
  assign DEBUG_SETTINGS = settings_q;
  assign BUSY           = (state_q != ST_IDLE);
  assign DONE           = done_q;
  assign DBG_FSM_STATE  = state_q;

endmodule

// File: tb/tb_debug_settings_ctl.sv
// Bench for debug_settings_ctl: four instances with RD_LATENCY 1..4 share one
// settings memory image and the same UPDATE / TIME_CNT stimulus.
module tb_debug_settings_ctl;
  import debug_settings_ctl_pkg::*;

  localparam int NI = 4;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_ARM   = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic update;
  logic [7:0] tc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Carrier counter: changes 1 time unit after each rising edge.
  initial begin
    tc = 8'd0;
    forever begin
      @(posedge clk);
      #1 tc = tc + 8'd1;
    end
  end

  // ---------------- DUTs and BRAM models ----------------
  logic [7:0]      addr [NI];
  logic            en   [NI];
  logic [15:0]     dout [NI];
  debug_settings_t ds   [NI];
  logic            busy [NI];
  logic            done [NI];
  logic [2:0]      fsm  [NI];
  logic [15:0]     mem  [8];

  int drain_cnt [NI] = '{default: 0};
  int done_cnt  [NI] = '{default: 0};

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [7:0] apipe [g+1];

      debug_settings_ctl #(
        .DEPTH      (249),
        .RD_LATENCY (g + 1),
        .BASE_ADDR  (8'h00)
      ) u_dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .UPDATE         (update),
        .TIME_CNT       (tc),
        .BRAM_ADDR      (addr[g]),
        .BRAM_EN        (en[g]),
        .BRAM_DOUT      (dout[g]),
        .DEBUG_SETTINGS (ds[g]),
        .BUSY           (busy[g]),
        .DONE           (done[g]),
        .DBG_FSM_STATE  (fsm[g])
      );

      always @(posedge clk) begin
        apipe[0] <= addr[g];
        for (int k = 1; k < g + 1; k++) apipe[k] <= apipe[k-1];
      end
      assign dout[g] = mem[apipe[g][2:0]];
    end
  endgenerate

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (fsm[i] == S_DRAIN) drain_cnt[i] <= drain_cnt[i] + 1;
      if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tc(input logic [7:0] t, input string name);
    int n;
    n = 0;
    while ((tc != t) && (n < 300)) begin
      step();
      n++;
    end
    checks++;
    if (tc != t) begin
      failures++;
      $display("FAIL %s: timeout, tc=%0d expected %0d", name, tc, t);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0][15:0] ty;
    logic [3:0][15:0] va;
    logic [3:0][7:0]  ety;
    logic [3:0][15:0] eva;
  } vec_t;

  vec_t vecs [4];

  function automatic vec_t mk_vec(
    input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2, input logic [15:0] t3,
    input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3,
    input logic [7:0]  e0, input logic [7:0]  e1, input logic [7:0]  e2, input logic [7:0]  e3,
    input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] f2, input logic [15:0] f3);
    vec_t r;
    r.ty[0] = t0;  r.ty[1] = t1;  r.ty[2] = t2;  r.ty[3] = t3;
    r.va[0] = v0;  r.va[1] = v1;  r.va[2] = v2;  r.va[3] = v3;
    r.ety[0] = e0; r.ety[1] = e1; r.ety[2] = e2; r.ety[3] = e3;
    r.eva[0] = f0; r.eva[1] = f1; r.eva[2] = f2; r.eva[3] = f3;
    return r;
  endfunction

  function automatic debug_settings_t exp_of(input vec_t v);
    debug_settings_t e;
    for (int j = 0; j < 4; j++) begin
      e.dbg_type[j]  = v.ety[j];
      e.dbg_value[j] = v.eva[j];
    end
    return e;
  endfunction

  task automatic load_mem(input vec_t v);
    for (int j = 0; j < 4; j++) begin
      mem[j]     = v.ty[j];
      mem[j + 4] = v.va[j];
    end
  endtask

  // ---------------- main sequence ----------------
  debug_settings_t prev_exp;
  debug_settings_t cur_exp;
  int d0 [NI];
  int n0 [NI];
  logic ok;
  int n;

  initial begin
    // basic load
    vecs[0] = mk_vec(16'd1, 16'd4, 16'd10, 16'd11, 16'd0, 16'd0, 16'd17, 16'd1,
                     8'd1, 8'd4, 8'd10, 8'd11, 16'd0, 16'd0, 16'd17, 16'd1);
    // unknown type, PWM_OUT at and below DEPTH, MOD_IDX mask
    vecs[1] = mk_vec(16'h007F, 16'd10, 16'd10, 16'd6, 16'h1234, 16'd249, 16'd248, 16'hFFFF,
                     8'd0, 8'd0, 8'd10, 8'd6, 16'd0, 16'd0, 16'd248, 16'h7FFF);
    // STM_IDX mask with junk upper type bits, DIRECT mask, type 12 unknown
    vecs[2] = mk_vec(16'hAB08, 16'd11, 16'd12, 16'd5, 16'hFFFF, 16'hFFFE, 16'd5, 16'd3,
                     8'd8, 8'd11, 8'd0, 8'd5, 16'h1FFF, 16'd0, 16'd0, 16'd3);
    // DIRECT keeps bit 0, MOD_IDX drops bit 15, PWM_OUT 0 kept, THERMO unmasked
    vecs[3] = mk_vec(16'd11, 16'hFF06, 16'd10, 16'd2, 16'hFFFF, 16'h8000, 16'd0, 16'hABCD,
                     8'd11, 8'd6, 8'd10, 8'd2, 16'd1, 16'd0, 16'd0, 16'hABCD);

    rst_n  = 1'b0;
    update = 1'b0;
    load_mem(vecs[0]);
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_outputs_l%0d", i + 1),
            {ds[i], addr[i], en[i], busy[i], done[i]}, '0);
    end
    rst_n = 1'b1;
    step();
    prev_exp = '0;

    // table-driven loads, all latencies in parallel
    for (int v = 0; v < 4; v++) begin
      load_mem(vecs[v]);
      cur_exp = exp_of(vecs[v]);
      wait_tc(8'd10, "wait_req_slot");
      for (int i = 0; i < NI; i++) begin
        d0[i] = drain_cnt[i];
        n0[i] = done_cnt[i];
      end
      update = 1'b1;
      step();
      update = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (!(en[1] && (addr[1] == 8'(k)))) ok = 1'b0;
        step();
      end
      check($sformatf("addr_seq_v%0d", v), ok, 1'b1);
      check($sformatf("en_off_v%0d", v), en[1], 1'b0);
      wait_tc(8'd255, "wait_commit_slot");
      check($sformatf("hold_before_commit_v%0d", v), {ds[1], busy[1], done[1]},
            {prev_exp, 1'b1, 1'b0});
      step();
      check($sformatf("commit_flags_v%0d", v), {done[1], busy[1]}, 2'b10);
      for (int i = 0; i < NI; i++) begin
        check($sformatf("settings_v%0d_l%0d", v, i + 1), ds[i], cur_exp);
      end
      repeat (4) step();
      for (int i = 0; i < NI; i++) begin
        check($sformatf("drain_len_v%0d_l%0d", v, i + 1), drain_cnt[i] - d0[i], i + 1);
        check($sformatf("done_count_v%0d_l%0d", v, i + 1), done_cnt[i] - n0[i], 1);
      end
      prev_exp = cur_exp;
    end

    // boundary: request at tc=243 puts the RD_LATENCY=2 instance into ARM at tc=255,
    // and the RD_LATENCY=3 instance into ARM at tc=0
    load_mem(vecs[1]);
    cur_exp = exp_of(vecs[1]);
    wait_tc(8'd243, "wait_boundary_req");
    update = 1'b1;
    step();
    update = 1'b0;
    wait_tc(8'd255, "wait_boundary_ff");
    check("arm_at_ff_l2", fsm[1], S_ARM);
    check("check_at_ff_l3", fsm[2], S_CHECK);
    step();
    check("boundary_done_l1", done[0], 1'b1);
    check("boundary_done_l2", done[1], 1'b1);
    check("boundary_settings_l2", ds[1], cur_exp);
    check("arm_at_zero_l3", {fsm[2], done[2]}, {S_ARM, 1'b0});
    check("settings_held_l3", ds[2], prev_exp);
    n = 0;
    while (!done[2] && (n < 300)) begin
      step();
      n++;
    end
    check("arm_zero_wait_l3", n, 256);
    check("boundary_settings_l3", ds[2], cur_exp);
    check("boundary_done_l4", done[3], 1'b1);
    prev_exp = cur_exp;

    // back-to-back: three extra UPDATE edges during READ become one pending load
    load_mem(vecs[0]);
    wait_tc(8'd10, "wait_b2b_req");
    for (int i = 0; i < NI; i++) n0[i] = done_cnt[i];
    update = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      update = 1'b0;
      step();
      update = 1'b1;
      step();
    end
    update = 1'b0;
    n = 0;
    while (!((fsm[0] == S_ARM) && (fsm[1] == S_ARM) && (fsm[2] == S_ARM) && (fsm[3] == S_ARM))
           && (n < 50)) begin
      step();
      n++;
    end
    check("b2b_all_armed", n < 50, 1'b1);
    load_mem(vecs[2]);
    wait_tc(8'd255, "wait_b2b_first");
    step();
    check("b2b_first_settings", ds[1], exp_of(vecs[0]));
    check("b2b_restart_read", {fsm[1], busy[1], done[1]}, {S_READ, 1'b1, 1'b1});
    step();
    wait_tc(8'd255, "wait_b2b_second");
    repeat (300) step();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("b2b_done_count_l%0d", i + 1), done_cnt[i] - n0[i], 2);
      check($sformatf("b2b_final_settings_l%0d", i + 1), ds[i], exp_of(vecs[2]));
    end

    // reset during DRAIN, with UPDATE held high across reset
    load_mem(vecs[3]);
    wait_tc(8'd10, "wait_rst_req");
    update = 1'b1;
    step();
    n = 0;
    while ((fsm[1] != S_DRAIN) && (n < 20)) begin
      step();
      n++;
    end
    check("reached_drain_l2", fsm[1], S_DRAIN);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("async_reset_l%0d", i + 1),
            {ds[i], addr[i], en[i], busy[i], done[i]}, '0);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) n0[i] = done_cnt[i];
    repeat (600) step();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("no_load_after_reset_l%0d", i + 1),
            {ds[i], busy[i], 32'(done_cnt[i] - n0[i])}, '0);
    end
    update = 1'b0;
    step();
    update = 1'b1;
    step();
    update = 1'b0;
    wait_tc(8'd255, "wait_post_reset_commit");
    step();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("post_reset_settings_l%0d", i + 1), ds[i], exp_of(vecs[3]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
